// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared PWM definitions: controller state encoding and default widths/divider
// used by every block in the PWM datapath.
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  localparam int PWM_N        = 8;
  localparam int PWM_S        = 4;
  localparam int PWM_RAMP_DIV = 4;

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Command / status bundle between the control logic (master) and the
// soft-start sequencer (slave), including the PWM wrap strobe and duty output.
interface pwm_ramp_ctrl_if
  import pwm_pkg::*;
#(
  parameter int N = PWM_N,
  parameter int S = PWM_S
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [N-1:0] cmd_target;
  logic [S-1:0] cmd_step;
  logic         stop_req;
  logic         period_wrap;
  logic [N-1:0] duty_cycle;
  logic         busy;
  logic         done;

  modport master (
    output cmd_valid, cmd_target, cmd_step, stop_req, period_wrap,
    input  cmd_ready, duty_cycle, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_step, stop_req, period_wrap,
    output cmd_ready, duty_cycle, busy, done
  );
endinterface

// File: rtl/pwm_ramp_ctrl_period_div.sv
// Counts PWM period wraps while enabled and flags the wrap on which a duty
// step is due (every RAMP_DIV-th wrap).
module pwm_period_div #(
  parameter int RAMP_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  input  logic wrap,
  output logic step_tick
);
  localparam int W = $clog2(RAMP_DIV) + 1;
  localparam logic [W-1:0] LAST = W'(RAMP_DIV - 1);

  logic [W-1:0] r_cnt;

  assign step_tick = en && wrap && (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clr || step_tick) begin
      r_cnt <= '0;
    end else if (en && wrap) begin
      r_cnt <= r_cnt + W'(1);
    end
  end
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer: walks duty_cycle toward a commanded target in
// saturating steps, only on PWM period wraps, with a level stop forcing ramp to 0.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int N        = PWM_N,
  parameter int S        = PWM_S,
  parameter int RAMP_DIV = PWM_RAMP_DIV
) (
  input logic           clk,
  input logic           reset_n,
  pwm_ramp_ctrl_if.slave bus
);
  state_t       r_state;
  logic [N-1:0] r_duty;
  logic [N-1:0] r_target;
  logic [S-1:0] r_step;
  logic         r_done;

  logic         w_accept;
  logic         w_tick;
  logic         w_en;
  logic [S-1:0] w_cmd_step;
  logic [N-1:0] w_tgt;
  logic [N:0]   w_step_x;
  logic [N:0]   w_sum;
  logic [N:0]   w_diff;
  logic [N-1:0] w_up;
  logic [N-1:0] w_dn;

  assign bus.cmd_ready  = (r_state == ST_IDLE) && !bus.stop_req;
  assign bus.duty_cycle = r_duty;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.done       = r_done;

  assign w_accept   = bus.cmd_valid && bus.cmd_ready;
  assign w_cmd_step = (bus.cmd_step == '0) ? S'(1) : bus.cmd_step;
  assign w_en       = (r_state != ST_IDLE);

  // A held stop keeps the effective target at zero even before r_target settles.
  assign w_tgt    = bus.stop_req ? '0 : r_target;
  assign w_step_x = (N+1)'(r_step);
  assign w_sum    = {1'b0, r_duty} + w_step_x;
  assign w_diff   = {1'b0, r_duty} - w_step_x;
  assign w_up     = (w_sum >= {1'b0, w_tgt}) ? w_tgt : w_sum[N-1:0];
  assign w_dn     = (w_diff[N] || (w_diff[N-1:0] <= w_tgt)) ? w_tgt : w_diff[N-1:0];

  pwm_period_div #(.RAMP_DIV(RAMP_DIV)) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (w_accept),
    .en        (w_en),
    .wrap      (bus.period_wrap),
    .step_tick (w_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_duty   <= '0;
      r_target <= '0;
      r_step   <= S'(1);
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.stop_req) r_target <= '0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.stop_req) begin
            if (r_duty != '0) r_state <= ST_DOWN;
          end else if (w_accept) begin
            r_target <= bus.cmd_target;
            r_step   <= w_cmd_step;
            if (bus.cmd_target > r_duty)      r_state <= ST_UP;
            else if (bus.cmd_target < r_duty) r_state <= ST_DOWN;
            else                              r_done  <= 1'b1;
          end
        end
        ST_UP: begin
          if (bus.stop_req) begin
            if (r_duty != '0) begin
              r_state <= ST_DOWN;
            end else begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end else if (w_tick) begin
            r_duty <= w_up;
            if (w_up == r_target) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DOWN: begin
          if (w_tick) begin
            r_duty <= w_dn;
            if (w_dn == w_tgt) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: table of ramp commands with hand-computed
// duty sequences, plus stop, equal-target, alignment and async-reset sequences.
module tb_pwm_ramp_ctrl;
  logic clk;
  logic reset_n;

  pwm_ramp_ctrl_if #(.N(8), .S(4)) bus ();

  pwm_ramp_ctrl #(.N(8), .S(4), .RAMP_DIV(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int target;
    int step;
    int len;
  } vec_t;

  vec_t vecs [4];
  int   exp_seq [4][17];

  int n_cmp = 0;
  int n_err = 0;
  int busy_wraps = 0;
  int done_cnt = 0;
  int prev_duty = 0;
  bit prev_busy = 0;
  bit skip_align = 1;
  bit wrap_en = 1;
  int last_duty = 0;
  logic [7:0] wcnt = 8'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Wrap pulse every 256 cycles, driven away from the sampling edge.
  initial begin
    bus.period_wrap = 1'b0;
    forever begin
      @(negedge clk);
      wcnt = wcnt + 8'd1;
      bus.period_wrap = wrap_en && (wcnt == 8'd255);
    end
  end

  // Duty may only move on an edge where period_wrap was sampled high.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!skip_align && int'(bus.duty_cycle) != prev_duty) begin
        n_cmp++;
        if (!bus.period_wrap) begin
          n_err++;
          $display("FAIL align: duty moved %0d->%0d with period_wrap=0", prev_duty, bus.duty_cycle);
        end
      end
      if (bus.period_wrap && prev_busy) busy_wraps++;
      if (bus.done) done_cnt++;
      prev_duty = int'(bus.duty_cycle);
      prev_busy = bus.busy;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_change(output int v, output bit ok, inout bit rdy, inout bit bl);
    ok = 0;
    v  = last_duty;
    for (int c = 0; c < 1400; c++) begin
      @(negedge clk);
      if (int'(bus.duty_cycle) != last_duty) begin
        ok = 1;
        v = int'(bus.duty_cycle);
        last_duty = v;
        break;
      end
      if (bus.cmd_ready) rdy = 1;
      if (!bus.busy) bl = 1;
    end
  endtask

  task automatic issue(input int tgt, input int stp);
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = 8'(tgt);
    bus.cmd_step   = 4'(stp);
    @(negedge clk);
    bus.cmd_valid  = 1'b0;
  endtask

  task automatic run_vec(input int vi);
    int v;
    bit ok;
    bit rdy;
    bit bl;
    int w0;
    int d0;
    rdy = 0;
    bl  = 0;
    check($sformatf("ready_before_cmd v%0d", vi), bus.cmd_ready, 1);
    issue(vecs[vi].target, vecs[vi].step);
    w0 = busy_wraps;
    d0 = done_cnt;
    check($sformatf("busy_after_accept v%0d", vi), bus.busy, 1);
    for (int i = 0; i < vecs[vi].len; i++) begin
      wait_change(v, ok, rdy, bl);
      check($sformatf("step_in_time v%0d s%0d", vi, i), ok, 1);
      check($sformatf("duty v%0d s%0d", vi, i), v, exp_seq[vi][i]);
    end
    check($sformatf("done_at_target v%0d", vi), bus.done, 1);
    check($sformatf("busy_clear v%0d", vi), bus.busy, 0);
    check($sformatf("ready_low_in_ramp v%0d", vi), rdy, 0);
    check($sformatf("busy_held v%0d", vi), bl, 0);
    @(negedge clk);
    check($sformatf("done_one_cycle v%0d", vi), bus.done, 0);
    check($sformatf("done_count v%0d", vi), done_cnt - d0, 1);
    check($sformatf("wraps_busy v%0d", vi), busy_wraps - w0, 4 * vecs[vi].len);
  endtask

  initial begin
    int v;
    bit ok;
    bit rdy;
    bit bl;
    bit moved;
    int w0;
    int d0;

    vecs[0] = '{target: 100, step: 10, len: 10};
    vecs[1] = '{target: 255, step: 15, len: 11};
    vecs[2] = '{target: 3,   step: 15, len: 17};
    vecs[3] = '{target: 6,   step: 0,  len: 3};
    exp_seq = '{
      '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100, 0, 0, 0, 0, 0, 0, 0},
      '{115, 130, 145, 160, 175, 190, 205, 220, 235, 250, 255, 0, 0, 0, 0, 0, 0},
      '{240, 225, 210, 195, 180, 165, 150, 135, 120, 105, 90, 75, 60, 45, 30, 15, 3},
      '{4, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}
    };

    reset_n        = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_target = 8'd0;
    bus.cmd_step   = 4'd0;
    bus.stop_req   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_duty", bus.duty_cycle, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    reset_n = 1'b1;
    @(negedge clk);
    skip_align = 0;
    last_duty  = 0;
    check("ready_after_reset", bus.cmd_ready, 1);

    // Ramp up, saturate at 255, ramp down to 3, step=0 treated as 1.
    for (int vi = 0; vi < 4; vi++) run_vec(vi);

    // Equal target: done next cycle, never busy.
    issue(6, 2);
    check("eq_done", bus.done, 1);
    check("eq_busy", bus.busy, 0);
    @(negedge clk);
    check("eq_done_cleared", bus.done, 0);
    check("eq_duty", bus.duty_cycle, 6);

    // Async reset mid-ramp, asserted between clock edges.
    rdy = 0;
    bl  = 0;
    issue(50, 10);
    wait_change(v, ok, rdy, bl);
    check("rst_pre_step", v, 16);
    #2;
    skip_align = 1;
    reset_n = 1'b0;
    #1;
    check("async_rst_duty", bus.duty_cycle, 0);
    check("async_rst_busy", bus.busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    skip_align = 0;
    last_duty  = 0;
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_done", bus.done, 0);

    // Soft stop at duty 60 of a 0->100 ramp; the new ramp also starts from 0.
    rdy = 0;
    bl  = 0;
    d0  = done_cnt;
    issue(100, 10);
    w0  = busy_wraps;
    for (int i = 0; i < 6; i++) begin
      wait_change(v, ok, rdy, bl);
      check($sformatf("stop_up s%0d", i), v, (i + 1) * 10);
    end
    bus.stop_req = 1'b1;
    #1;
    check("ready_low_on_stop", bus.cmd_ready, 0);
    @(negedge clk);
    bus.stop_req = 1'b0;
    check("busy_after_stop", bus.busy, 1);
    check("ready_low_in_down", bus.cmd_ready, 0);
    for (int i = 0; i < 6; i++) begin
      wait_change(v, ok, rdy, bl);
      check($sformatf("stop_in_time s%0d", i), ok, 1);
      check($sformatf("stop_down s%0d", i), v, 50 - 10 * i);
    end
    check("stop_done", bus.done, 1);
    check("stop_idle", bus.busy, 0);
    check("stop_ready_low", rdy, 0);
    check("stop_busy_held", bl, 0);
    @(negedge clk);
    check("stop_done_count", done_cnt - d0, 1);
    check("stop_wraps", busy_wraps - w0, 48);

    // Stop and cmd_valid together in IDLE at duty 0: nothing happens.
    d0 = done_cnt;
    bus.stop_req   = 1'b1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = 8'd77;
    bus.cmd_step   = 4'd3;
    #1;
    check("stop_cmd_ready", bus.cmd_ready, 0);
    @(negedge clk);
    bus.stop_req  = 1'b0;
    bus.cmd_valid = 1'b0;
    check("stop_cmd_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    check("stop_cmd_no_done", done_cnt - d0, 0);
    check("stop_cmd_duty", bus.duty_cycle, 0);
    check("stop_cmd_ready_back", bus.cmd_ready, 1);

    // No wraps for 10k cycles: duty stays frozen while ramping.
    wrap_en = 0;
    @(negedge clk);
    issue(50, 5);
    check("frozen_busy", bus.busy, 1);
    moved = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (bus.duty_cycle != 8'd0) moved = 1;
    end
    check("frozen_duty", moved, 0);
    check("frozen_still_busy", bus.busy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
